seq_divider: RTL and testbench

- Multi-cycle restoring divider; the inverse datapath to the team's combinational array multiplier.
- Takes a 2N-bit dividend (multiplier product width) and an N-bit divisor. Produces a 2N-bit quotient and an N-bit remainder, one quotient bit per clock.
- Uses a start/busy/done handshake so a controller can recover an operand from a product, or do general integer division, without a wide combinational divider.

---
 rtl/seq_divider.sv | 116 +++++++++++
 tb/tb_seq_divider.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Start/busy/done handshake; divide-by-zero short-circuits to DONE with an all-ones quotient.
module seq_divider #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   quotient,
    output logic [N-1:0]     remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(2 * N);
    localparam logic [CW-1:0] LAST = CW'(2 * N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [2*N-1:0]  d;
    logic [N-1:0]    v;
    logic [N-1:0]    r;
    logic [2*N-1:0]  q;
    logic [CW-1:0]   cnt;

    logic [N:0]      r_shift;
    logic            qbit;
    logic [N-1:0]    r_next;
    logic [2*N-1:0]  q_next;

    // One restoring step on the (N+1)-bit shifted remainder. When the subtraction is
    // taken the true difference is below V, so an N-bit subtract is exact.
    function automatic logic [N:0] restore_step(input logic [N:0] rs, input logic [N-1:0] vin);
        logic          take;
        logic [N-1:0]  rn;
        take = (rs >= {1'b0, vin});
        rn   = take ? (rs[N-1:0] - vin) : rs[N-1:0];
        return {take, rn};
    endfunction

    // The held partial remainder is always below V, so its top bit is implicitly zero
    // and only the shifted-in R' needs the extra compare bit.
    always_comb begin
        r_shift        = {r, d[2*N-1]};
        {qbit, r_next} = restore_step(r_shift, v);
        q_next         = {q[2*N-2:0], qbit};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            d           <= '0;
            v           <= '0;
            r           <= '0;
            q           <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        d   <= dividend;
                        v   <= divisor;
                        r   <= '0;
                        q   <= '0;
                        cnt <= '0;
                        if (divisor == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                            quotient    <= '1;
                            remainder   <= '0;
                        end else begin
                            state       <= RUN;
                            busy        <= 1'b1;
                            div_by_zero <= 1'b0;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    r   <= r_next;
                    q   <= q_next;
                    d   <= {d[2*N-2:0], 1'b0};
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= q_next;
                        remainder <= r_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive-sweep bench for seq_divider (N=4).
module tb_seq_divider;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [2*N-1:0] dividend = '0;
    logic [N-1:0]   divisor = '0;
    logic           busy;
    logic           done;
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
    logic           div_by_zero;

    int n_chk = 0;
    int n_pass = 0;

    seq_divider #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    // Drive start for one cycle; returns at the first negedge after the accepting edge.
    task automatic issue(input logic [2*N-1:0] dd, input logic [N-1:0] dv);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the first negedge after acceptance; returns at the negedge where done=1.
    task automatic wait_done(output int lat, output int bcyc);
        lat  = 1;
        bcyc = 0;
        while (!done && lat < 50) begin
            if (busy) bcyc++;
            @(negedge clk);
            lat++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic run_div(input logic [2*N-1:0] dd, input logic [N-1:0] dv,
                           output int lat, output int bcyc);
        issue(dd, dv);
        wait_done(lat, bcyc);
    endtask

    initial begin
        int lat, bcyc, pulses, done_lat;
        logic [2*N-1:0] got_q;
        logic [N-1:0]   got_r;
        logic [2*N-1:0] prod;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_q", {24'd0, quotient}, 0);
        chk("rst_r", {28'd0, remainder}, 0);
        chk("rst_dbz", {31'd0, div_by_zero}, 0);

        // 143 / 11 = 13 r 0
        run_div(8'd143, 4'd11, lat, bcyc);
        chk("t1_lat", lat, 9);
        chk("t1_busy", bcyc, 8);
        chk("t1_q", {24'd0, quotient}, 13);
        chk("t1_r", {28'd0, remainder}, 0);
        chk("t1_dbz", {31'd0, div_by_zero}, 0);
        @(negedge clk);
        chk("t1_done_pulse", {31'd0, done}, 0);
        chk("t1_q_held", {24'd0, quotient}, 13);

        // 200 / 7 = 28 r 4, then back-to-back 255 / 1 from the done cycle
        run_div(8'd200, 4'd7, lat, bcyc);
        chk("t2_q", {24'd0, quotient}, 28);
        chk("t2_r", {28'd0, remainder}, 4);
        issue(8'd255, 4'd1);
        chk("t2b_busy", {31'd0, busy}, 1);
        chk("t2b_q_old", {24'd0, quotient}, 28);
        chk("t2b_r_old", {28'd0, remainder}, 4);
        wait_done(lat, bcyc);
        chk("t2b_lat", lat, 9);
        chk("t2b_q", {24'd0, quotient}, 255);
        chk("t2b_r", {28'd0, remainder}, 0);
        @(negedge clk);

        // 90 / 0: divide by zero
        run_div(8'd90, 4'd0, lat, bcyc);
        chk("t3_lat", lat, 1);
        chk("t3_busy", {31'd0, busy}, 0);
        chk("t3_dbz", {31'd0, div_by_zero}, 1);
        chk("t3_q", {24'd0, quotient}, 255);
        chk("t3_r", {28'd0, remainder}, 0);
        @(negedge clk);
        chk("t3_done_pulse", {31'd0, done}, 0);
        chk("t3_dbz_held", {31'd0, div_by_zero}, 1);

        // 60 / 5 with an ignored start of 99 / 9 during RUN
        issue(8'd60, 4'd5);
        pulses   = 0;
        done_lat = 0;
        got_q    = '0;
        got_r    = '0;
        for (int i = 1; i <= 20; i++) begin
            if (done) begin
                pulses++;
                done_lat = i;
                got_q = quotient;
                got_r = remainder;
            end
            if (i == 4) begin
                start    = 1'b1;
                dividend = 8'd99;
                divisor  = 4'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk("t4_pulses", pulses, 1);
        chk("t4_lat", done_lat, 9);
        chk("t4_q", {24'd0, got_q}, 12);
        chk("t4_r", {28'd0, got_r}, 0);

        // Reset mid-RUN discards the division
        issue(8'd143, 4'd11);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_busy", {31'd0, busy}, 0);
        chk("t5_done", {31'd0, done}, 0);
        chk("t5_q", {24'd0, quotient}, 0);
        chk("t5_r", {28'd0, remainder}, 0);
        chk("t5_dbz", {31'd0, div_by_zero}, 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        chk("t5_no_done", pulses, 0);
        run_div(8'd143, 4'd11, lat, bcyc);
        chk("t5_fresh_lat", lat, 9);
        chk("t5_fresh_q", {24'd0, quotient}, 13);
        chk("t5_fresh_r", {28'd0, remainder}, 0);

        // Full sweep of nonzero divisors
        for (int dv = 1; dv < 16; dv++) begin
            for (int dd = 0; dd < 256; dd++) begin
                run_div(8'(dd), 4'(dv), lat, bcyc);
                chk("sweep_q", {24'd0, quotient}, dd / dv);
                chk("sweep_r", {28'd0, remainder}, dd % dv);
            end
        end

        // Recover B from the product A*B
        for (int a = 1; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                prod = 8'(a * b);
                run_div(prod, 4'(a), lat, bcyc);
                chk("mul_q", {24'd0, quotient}, b);
                chk("mul_r", {28'd0, remainder}, 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
